// File: rtl/mips_pkg.sv
// Shared write-back mode encoding and lane constants for the MIPS register file slice.
package mips_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        WB_WORD = 3'd0,
        WB_LB   = 3'd1,
        WB_LBU  = 3'd2,
        WB_LH   = 3'd3,
        WB_LHU  = 3'd4,
        WB_LWL  = 3'd5,
        WB_LWR  = 3'd6
    } wb_mode_t;

endpackage

// File: rtl/load_merge.sv
// Combinational load-data alignment: extracts, extends or merges the raw memory word
// against the old register value according to the write-back mode and address offset.
module load_merge
    import mips_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [1:0]  ofs,
    input  logic [31:0] raw,
    input  logic [31:0] old,
    output logic [31:0] result,
    output logic        write_ok,
    output logic        misalign
);

    logic [BYTE_W-1:0]   w_byte;
    logic [2*BYTE_W-1:0] w_half;
    logic [4:0]          w_lwlShift;
    logic [4:0]          w_lwrShift;
    logic                w_signed;

    // LWL shifts by 8*(3-k); for a 2-bit k, 3-k is simply ~k.
    assign w_lwlShift = {~ofs, 3'b000};
    assign w_lwrShift = {ofs, 3'b000};

    always_comb begin
        result   = raw;
        write_ok = 1'b1;
        misalign = 1'b0;
        w_byte   = raw[BYTE_W*ofs +: BYTE_W];
        w_half   = ofs[1] ? raw[31:16] : raw[15:0];
        w_signed = 1'b0;
        case (mode)
            WB_WORD: result = raw;
            WB_LB, WB_LBU: begin
                w_signed = (mode == WB_LB) && w_byte[BYTE_W-1];
                result   = {{(32-BYTE_W){w_signed}}, w_byte};
            end
            WB_LH, WB_LHU: begin
                w_signed = (mode == WB_LH) && w_half[2*BYTE_W-1];
                result   = {{(32-2*BYTE_W){w_signed}}, w_half};
                if (ofs[0]) begin
                    write_ok = 1'b0;
                    misalign = 1'b1;
                end
            end
            WB_LWL: result = (raw << w_lwlShift) | (old & ~(32'hFFFF_FFFF << w_lwlShift));
            WB_LWR: result = (raw >> w_lwrShift) | (old & ~(32'hFFFF_FFFF >> w_lwrShift));
            default: write_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/regfile_wb_merge.sv
// MIPS GPR file with load-merging write port, bypassed combinational read ports
// and a per-register pending-load scoreboard for load-use stalls.
module regfile_wb_merge
    import mips_pkg::*;
#(
    parameter int  NUM_REGS     = 32,
    parameter int  NUM_RD_PORTS = 2,
    parameter bit  BYPASS_EN    = 1'b1,
    localparam int AW           = $clog2(NUM_REGS)
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [2:0]                 wr_mode,
    input  logic [1:0]                 wr_ofs,
    input  logic [31:0]                wr_data,
    input  logic                       pend_set,
    input  logic [AW-1:0]              pend_addr,
    input  logic [NUM_RD_PORTS*AW-1:0] rd_addr,
    output logic [NUM_RD_PORTS*32-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]    rd_pending,
    output logic                       wr_misalign
);

    logic [31:0]         r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic [31:0]         w_result;
    logic                w_writeOk;
    logic                w_misalign;
    logic                w_doWrite;

    load_merge u_merge (
        .mode     (wr_mode),
        .ofs      (wr_ofs),
        .raw      (wr_data),
        .old      (r_regs[wr_addr]),
        .result   (w_result),
        .write_ok (w_writeOk),
        .misalign (w_misalign)
    );

    assign w_doWrite = wr_en && w_writeOk && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            wr_misalign <= 1'b0;
        end else begin
            if (w_doWrite) begin
                r_regs[wr_addr] <= w_result;
            end
            wr_misalign <= wr_en && w_misalign;
        end
    end

    // Clear on any write-back, then set from a new load; the later assignment lets set win.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            if (wr_en) begin
                r_pend[wr_addr] <= 1'b0;
            end
            if (pend_set && (pend_addr != '0)) begin
                r_pend[pend_addr] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_hit;

        assign w_addr = rd_addr[p*AW +: AW];
        assign w_hit  = BYPASS_EN && w_doWrite && (wr_addr == w_addr);

        always_comb begin
            rd_data[p*32 +: 32] = r_regs[w_addr];
            rd_pending[p]       = r_pend[w_addr];
            if (w_addr == '0) begin
                rd_data[p*32 +: 32] = '0;
                rd_pending[p]       = 1'b0;
            end else if (w_hit) begin
                rd_data[p*32 +: 32] = w_result;
                rd_pending[p]       = 1'b0;
            end
        end
    end

endmodule
